iob_arb2: RTL and testbench

Two-master round-robin arbiter for the native (valid/ready) bus. It shares a single native slave port, typically a peripheral or the AXI-Lite-to-native bridge's downstream target, between two native masters, for example a CPU and a DMA or bridge output. It serialises transactions, routes each response back to the master that issued it, and aborts any transaction the slave does not answer within a programmable number of cycles.

---
 rtl/iob_arb2.sv | 128 ++++++++++++
 tb/tb_iob_arb2.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_arb2.sv
// iob_arb2: two-master round-robin arbiter for the native valid/ready bus.
// Serialises requests from m0/m1 onto one slave port, returns each response
// to the master that issued it, and aborts transactions the slave leaves
// unanswered for TIMEOUT cycles (TIMEOUT = 0 disables the watchdog).
module iob_arb2 #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  m0_valid,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_ready,
    output logic                  m0_err,

    input  logic                  m1_valid,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_ready,
    output logic                  m1_err,

    output logic                  s_valid,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic                  s_ready
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam logic [TIMEOUT_W-1:0] CNT_LIMIT = TIMEOUT_W'(TIMEOUT);
    localparam logic                 WDOG_EN   = (TIMEOUT != 0);

    logic                 state_q, state_d;
    logic                 grant_q, grant_d;   // master currently owning the slave
    logic                 last_q,  last_d;    // master served most recently
    logic [TIMEOUT_W-1:0] cnt_q,   cnt_d;     // BUSY cycles without a response

    logic busy;
    logic abort;
    logic done;

    assign busy  = (state_q == ST_BUSY);
    // The abort cycle takes precedence over any coincident s_ready.
    assign abort = busy && WDOG_EN && (cnt_q == CNT_LIMIT);
    assign done  = busy && (abort || s_ready);

    // Arbitration and transaction-tracking next-state logic.
    // NOTE: every variable gets a default at the top so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (!busy) begin
            if (m0_valid || m1_valid) begin
                state_d = ST_BUSY;
                cnt_d   = '0;
                // Under contention the master that was not served last wins.
                grant_d = (m0_valid && m1_valid) ? ~last_q : m1_valid;
            end
        end else if (done) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
        end else begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    // State registers; last resets to 1 so m0 wins the first contention.
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request forwarding and response routing; all outputs are zero outside BUSY,
    // so an asynchronous reset clears them without waiting for a clock edge.
    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = '0;
        if (busy && !abort) begin
            s_valid = 1'b1;
            s_addr  = grant_q ? m1_addr  : m0_addr;
            s_wdata = grant_q ? m1_wdata : m0_wdata;
            s_wstrb = grant_q ? m1_wstrb : m0_wstrb;
        end
        if (done) begin
            if (grant_q) begin
                m1_ready = 1'b1;
                m1_err   = abort;
                m1_rdata = abort ? '0 : s_rdata;
            end else begin
                m0_ready = 1'b1;
                m0_err   = abort;
                m0_rdata = abort ? '0 : s_rdata;
            end
        end
    end

endmodule

// File: tb/tb_iob_arb2.sv
// tb_iob_arb2: self-checking bench for iob_arb2. Two instances share all
// inputs: u_dut4 (TIMEOUT=4) and u_dut0 (watchdog disabled).
module tb_iob_arb2;

    localparam int OW  = 137;  // packed width of one observation of all outputs
    localparam int TO4 = 4;

    localparam logic [31:0] A0  = 32'h0000_0010;
    localparam logic [31:0] A1  = 32'h0000_0020;
    localparam logic [31:0] WD1 = 32'h1234_5678;
    localparam logic [3:0]  WS1 = 4'hF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        m0_valid, m1_valid, s_ready;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;

    logic        d4_m0_ready, d4_m0_err, d4_m1_ready, d4_m1_err, d4_s_valid;
    logic [31:0] d4_m0_rdata, d4_m1_rdata, d4_s_addr, d4_s_wdata;
    logic [3:0]  d4_s_wstrb;
    logic        d0_m0_ready, d0_m0_err, d0_m1_ready, d0_m1_err, d0_s_valid;
    logic [31:0] d0_m0_rdata, d0_m1_rdata, d0_s_addr, d0_s_wdata;
    logic [3:0]  d0_s_wstrb;

    iob_arb2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO4), .TIMEOUT_W(8)) u_dut4 (
        .clk(clk), .rstn(rstn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rdata(d4_m0_rdata), .m0_ready(d4_m0_ready), .m0_err(d4_m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rdata(d4_m1_rdata), .m1_ready(d4_m1_ready), .m1_err(d4_m1_err),
        .s_valid(d4_s_valid), .s_addr(d4_s_addr), .s_wdata(d4_s_wdata), .s_wstrb(d4_s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    iob_arb2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0), .TIMEOUT_W(8)) u_dut0 (
        .clk(clk), .rstn(rstn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rdata(d0_m0_rdata), .m0_ready(d0_m0_ready), .m0_err(d0_m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rdata(d0_m1_rdata), .m1_ready(d0_m1_ready), .m1_err(d0_m1_err),
        .s_valid(d0_s_valid), .s_addr(d0_s_addr), .s_wdata(d0_s_wdata), .s_wstrb(d0_s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    logic [OW-1:0] obs4, obs0;
    assign obs4 = {d4_s_valid, d4_s_addr, d4_s_wdata, d4_s_wstrb,
                   d4_m0_ready, d4_m0_err, d4_m0_rdata, d4_m1_ready, d4_m1_err, d4_m1_rdata};
    assign obs0 = {d0_s_valid, d0_s_addr, d0_s_wdata, d0_s_wstrb,
                   d0_m0_ready, d0_m0_err, d0_m0_rdata, d0_m1_ready, d0_m1_err, d0_m1_rdata};

    int n_tests = 0;
    int n_fail  = 0;

    logic [OW-1:0] all_ones;
    logic [OW-1:0] fwd_mask;  // s_addr/s_wdata/s_wstrb bits, left unchecked in the abort cycle

    function automatic logic [OW-1:0] pack(input logic sv, input logic [31:0] sa, input logic [31:0] sw,
                                           input logic [3:0] ss, input logic r0, input logic e0,
                                           input logic [31:0] rd0, input logic r1, input logic e1,
                                           input logic [31:0] rd1);
        return {sv, sa, sw, ss, r0, e0, rd0, r1, e1, rd1};
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp,
                         input logic [OW-1:0] mask);
        n_tests++;
        if ((act & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (mask %h)", name, act, exp, mask);
        end
    endtask

    // One table row = one clock cycle: inputs {rstn,m0_valid,m1_valid,s_ready}
    // and expected {s_valid,grant,m0_ready,m0_err,m1_ready,m1_err}.
    typedef struct {
        logic [3:0]  in;
        logic [31:0] srd;
        logic [5:0]  ex;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] in, input logic [31:0] srd,
                                input logic [5:0] ex, input logic [31:0] rd);
        vec_t v;
        v.in = in; v.srd = srd; v.ex = ex; v.rd = rd;
        return v;
    endfunction

    function automatic logic [OW-1:0] row_exp(input vec_t v);
        logic sv, g, r0, e0, r1, e1;
        {sv, g, r0, e0, r1, e1} = v.ex;
        return pack(sv, sv ? (g ? A1 : A0) : 32'h0, sv ? (g ? WD1 : 32'h0) : 32'h0,
                    sv ? (g ? WS1 : 4'h0) : 4'h0,
                    r0, e0, (r0 && !e0) ? v.rd : 32'h0,
                    r1, e1, (r1 && !e1) ? v.rd : 32'h0);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [OW-1:0] exp;
        logic [OW-1:0] msk;
        int            bad;
        // behavioural model state for the random phase
        logic          mb;
        int            mo, ml, mage;
        logic          v[2], cool[2];
        logic [31:0]   a[2], wd[2];
        logic [3:0]    ws[2];
        logic          ab, sv;

        all_ones = '1;
        fwd_mask = pack(1'b0, '1, '1, '1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        rstn = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
        m0_addr = A0; m0_wdata = '0; m0_wstrb = '0;
        m1_addr = A1; m1_wdata = WD1; m1_wstrb = WS1;

        @(negedge clk);
        check("reset_d4", obs4, '0, all_ones);
        check("reset_d0", obs0, '0, all_ones);
        @(posedge clk); #1 rstn = 1'b1;

        // ---------------- directed cycle table ----------------
        tbl.push_back(mk(4'b1100, 32'h0,        6'b000000, 32'h0));        // m0 read request
        tbl.push_back(mk(4'b1100, 32'h0,        6'b100000, 32'h0));        // BUSY, waiting
        tbl.push_back(mk(4'b1101, 32'hCAFEF00D, 6'b101000, 32'hCAFEF00D)); // response
        tbl.push_back(mk(4'b1000, 32'h0,        6'b000000, 32'h0));
        tbl.push_back(mk(4'b1010, 32'h0,        6'b000000, 32'h0));        // m1 write request
        tbl.push_back(mk(4'b1010, 32'h0,        6'b110000, 32'h0));
        tbl.push_back(mk(4'b1011, 32'hDEAD0001, 6'b110010, 32'hDEAD0001));
        tbl.push_back(mk(4'b1001, 32'hBAD0BAD0, 6'b000000, 32'h0));        // s_ready in IDLE ignored
        tbl.push_back(mk(4'b0000, 32'h0,        6'b000000, 32'h0));        // reset
        tbl.push_back(mk(4'b1110, 32'h0,        6'b000000, 32'h0));        // contention from reset
        tbl.push_back(mk(4'b1111, 32'hA0A0A0A0, 6'b101000, 32'hA0A0A0A0)); // m0 first
        tbl.push_back(mk(4'b1010, 32'h0,        6'b000000, 32'h0));
        tbl.push_back(mk(4'b1011, 32'hB1B1B1B1, 6'b110010, 32'hB1B1B1B1)); // then m1
        tbl.push_back(mk(4'b1000, 32'h0,        6'b000000, 32'h0));
        tbl.push_back(mk(4'b1110, 32'h0,        6'b000000, 32'h0));        // contention, last=m1
        tbl.push_back(mk(4'b1111, 32'hC2C2C2C2, 6'b101000, 32'hC2C2C2C2)); // m0
        tbl.push_back(mk(4'b1010, 32'h0,        6'b000000, 32'h0));
        tbl.push_back(mk(4'b1011, 32'hD3D3D3D3, 6'b110010, 32'hD3D3D3D3)); // m1
        tbl.push_back(mk(4'b1100, 32'h0,        6'b000000, 32'h0));
        tbl.push_back(mk(4'b1101, 32'hE4E4E4E4, 6'b101000, 32'hE4E4E4E4)); // m0 alone, last=m0
        tbl.push_back(mk(4'b1000, 32'h0,        6'b000000, 32'h0));
        tbl.push_back(mk(4'b1110, 32'h0,        6'b000000, 32'h0));        // contention, last=m0
        tbl.push_back(mk(4'b1111, 32'hF5F5F5F5, 6'b110010, 32'hF5F5F5F5)); // m1 wins
        tbl.push_back(mk(4'b1100, 32'h0,        6'b000000, 32'h0));
        tbl.push_back(mk(4'b1101, 32'h06060606, 6'b101000, 32'h06060606));
        tbl.push_back(mk(4'b1000, 32'h0,        6'b000000, 32'h0));
        tbl.push_back(mk(4'b1100, 32'h0,        6'b000000, 32'h0));        // timeout: request
        for (int k = 0; k < TO4; k++)
            tbl.push_back(mk(4'b1100, 32'h0,    6'b100000, 32'h0));        // s_valid for 4 cycles
        tbl.push_back(mk(4'b1101, 32'h55555555, 6'b001100, 32'h0));        // abort, s_ready ignored
        tbl.push_back(mk(4'b1001, 32'h77777777, 6'b000000, 32'h0));        // late s_ready
        tbl.push_back(mk(4'b1000, 32'h0,        6'b000000, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            {rstn, m0_valid, m1_valid, s_ready} = tbl[i].in;
            s_rdata = tbl[i].srd;
            @(negedge clk);
            exp = row_exp(tbl[i]);
            msk = (tbl[i].ex[2] || tbl[i].ex[0]) ? ~fwd_mask : all_ones;
            check($sformatf("tbl4[%0d]", i), obs4, exp, msk);
            if (i < 26) check($sformatf("tbl0[%0d]", i), obs0, exp, msk);
        end

        // ---------------- asynchronous reset mid-transaction ----------------
        // Before this, last = m0 (aborted); only the reset can make m0 win again.
        @(posedge clk); #1; m0_valid = 1'b1; m1_valid = 1'b0; s_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_busy", obs4, pack(1'b1, A0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0), all_ones);
        #2 rstn = 1'b0;
        #1;
        check("rst_async_d4", obs4, '0, all_ones);
        check("rst_async_d0", obs0, '0, all_ones);
        @(posedge clk); #1; m1_valid = 1'b1;
        @(posedge clk); #1; rstn = 1'b1;
        @(negedge clk);
        check("rst_rel_idle", obs4, '0, all_ones);
        @(posedge clk); #1; s_ready = 1'b1; s_rdata = 32'h13579BDF;
        @(negedge clk);
        check("rst_m0_first", obs4, pack(1'b1, A0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h13579BDF, 1'b0, 1'b0, 32'h0), all_ones);
        @(posedge clk); #1; m0_valid = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        check("rst_gap", obs4, '0, all_ones);
        @(posedge clk); #1; s_ready = 1'b1; s_rdata = 32'h2468ACE0;
        @(negedge clk);
        check("rst_m1_next", obs4, pack(1'b1, A1, WD1, WS1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h2468ACE0), all_ones);
        @(posedge clk); #1; m1_valid = 1'b0; s_ready = 1'b0;

        // ---------------- watchdog disabled: slave answers after 1000 cycles ----------------
        @(posedge clk); #1; m0_valid = 1'b1;
        bad = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk); #1;
            s_ready = (k == 1000);
            s_rdata = (k == 1000) ? 32'h0D15EA5E : $urandom;
            @(negedge clk);
            if (k < 1000) begin
                if (obs0 !== pack(1'b1, A0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0)) bad++;
            end else begin
                check("to0_resp", obs0, pack(1'b1, A0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0D15EA5E, 1'b0, 1'b0, 32'h0), all_ones);
            end
        end
        check("to0_wait_bad_cycles", OW'(bad), '0, all_ones);
        @(posedge clk); #1; m0_valid = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        check("to0_after", obs0, '0, all_ones);

        // ---------------- randomized traffic against a transaction-level model ----------------
        @(posedge clk); #1; rstn = 1'b0;
        @(posedge clk); #1; rstn = 1'b1;
        mb = 1'b0; mo = 0; ml = 1; mage = 0;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; cool[i] = 1'b0; a[i] = '0; wd[i] = '0; ws[i] = '0;
        end
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (cool[i]) begin
                    v[i] = 1'b0;
                    cool[i] = 1'b0;
                end else if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i]  = 1'b1;
                    a[i]  = $urandom;
                    wd[i] = $urandom;
                    ws[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                end
            end
            m0_valid = v[0]; m0_addr = a[0]; m0_wdata = wd[0]; m0_wstrb = ws[0];
            m1_valid = v[1]; m1_addr = a[1]; m1_wdata = wd[1]; m1_wstrb = ws[1];
            s_ready  = ($urandom_range(0, 3) == 0);
            s_rdata  = $urandom;
            @(negedge clk);

            // A transaction is open (mb) for master mo and has waited mage cycles.
            ab  = mb && (mage == TO4);
            sv  = mb && !ab;
            exp = '0;
            if (mb)
                exp = pack(sv, sv ? a[mo] : 32'h0, sv ? wd[mo] : 32'h0, sv ? ws[mo] : 4'h0,
                           (mo == 0) && (ab || s_ready), (mo == 0) && ab,
                           ((mo == 0) && s_ready && !ab) ? s_rdata : 32'h0,
                           (mo == 1) && (ab || s_ready), (mo == 1) && ab,
                           ((mo == 1) && s_ready && !ab) ? s_rdata : 32'h0);
            check($sformatf("rand[%0d]", c), obs4, exp, ab ? ~fwd_mask : all_ones);

            if (mb) begin
                if (ab || s_ready) begin
                    mb = 1'b0;
                    ml = mo;
                    cool[mo] = 1'b1;
                end else begin
                    mage++;
                end
            end else if (v[0] || v[1]) begin
                mb   = 1'b1;
                mage = 0;
                mo   = (v[0] && v[1]) ? 1 - ml : (v[1] ? 1 : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
